// File: rtl/ipg_tx_serializer.sv
// ipg_tx_serializer
// Slices one {hdr, payload} IPG message MSB-first into the idle-byte slots
// offered by the 64b TX path. Each emitted chunk is left-justified, and
// tx_len gives its length in bits.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a message; s_msg_ready high; tx outputs held at 0
// S_SEND | shifting the message out, one chunk per usable slot
module ipg_tx_serializer #(
    parameter int MSG_WIDTH  = 520,
    parameter int HDR_WIDTH  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MSG_WIDTH-1:0]  s_msg_data,
    input  logic                  s_msg_valid,
    output logic                  s_msg_ready,
    input  logic [LEN_WIDTH-1:0]  slot_len,
    output logic [DATA_WIDTH-1:0] tx_ipg_data,
    output logic [LEN_WIDTH-1:0]  tx_len,
    output logic                  tx_ipg_valid,
    output logic                  msg_done,
    output logic                  busy
);

    localparam int PAYLOAD_WIDTH = MSG_WIDTH - HDR_WIDTH;
    localparam int BL_WIDTH      = $clog2(MSG_WIDTH + 1);

    // The message length is counted as header plus payload.
    localparam logic [BL_WIDTH-1:0]  MSG_BITS = BL_WIDTH'(HDR_WIDTH + PAYLOAD_WIDTH);
    localparam logic [LEN_WIDTH-1:0] SLOT_MAX = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] BYTE_LSB = LEN_WIDTH'(7);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [MSG_WIDTH-1:0]   sr_q, sr_d;
    logic [BL_WIDTH-1:0]    bits_left_q, bits_left_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [LEN_WIDTH-1:0]   tx_len_q, tx_len_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   msg_done_q, msg_done_d;

    logic [LEN_WIDTH-1:0]   eff_clamp;
    logic [LEN_WIDTH-1:0]   eff;
    logic [LEN_WIDTH-1:0]   n;
    logic [DATA_WIDTH-1:0]  head_mask;

    // Slot conditioning: clamp to one chunk, then round down to whole bytes,
    // and cap the take at what is left of the message.
    always_comb begin
        eff_clamp = (slot_len > SLOT_MAX) ? SLOT_MAX : slot_len;
        eff       = eff_clamp & ~BYTE_LSB;
        if (BL_WIDTH'(eff) > bits_left_q) begin
            // The remainder is smaller than a slot, so it fits in LEN_WIDTH bits.
            n = bits_left_q[LEN_WIDTH-1:0];
        end else begin
            n = eff;
        end
        head_mask = ~({DATA_WIDTH{1'b1}} >> n);
    end

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bits_left_d = bits_left_q;
        tx_data_d   = '0;
        tx_len_d    = '0;
        tx_valid_d  = 1'b0;
        msg_done_d  = 1'b0;
        s_msg_ready = 1'b0;
        busy        = 1'b0;

        case (state_q)
            S_IDLE: begin
                s_msg_ready = 1'b1;
                // The slot offered in the accept cycle is deliberately left unused.
                if (s_msg_valid) begin
                    sr_d        = s_msg_data;
                    bits_left_d = MSG_BITS;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                busy = 1'b1;
                // n == 0 is a stall: nothing shifts and no bits are lost.
                if (n != '0) begin
                    tx_data_d   = sr_q[MSG_WIDTH-1 -: DATA_WIDTH] & head_mask;
                    tx_len_d    = n;
                    tx_valid_d  = 1'b1;
                    sr_d        = sr_q << n;
                    bits_left_d = bits_left_q - BL_WIDTH'(n);
                    if (bits_left_q == BL_WIDTH'(n)) begin
                        msg_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, shift register and output registers. A reset drops any message in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bits_left_q <= '0;
            tx_data_q   <= '0;
            tx_len_q    <= '0;
            tx_valid_q  <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bits_left_q <= bits_left_d;
            tx_data_q   <= tx_data_d;
            tx_len_q    <= tx_len_d;
            tx_valid_q  <= tx_valid_d;
            msg_done_q  <= msg_done_d;
        end
    end

    assign tx_ipg_data  = tx_data_q;
    assign tx_len       = tx_len_q;
    assign tx_ipg_valid = tx_valid_q;
    assign msg_done     = msg_done_q;

endmodule

// File: tb/tb_ipg_tx_serializer.sv
// Scoreboard bench for ipg_tx_serializer. A driver pushes the expected chunks;
// a monitor pops and compares them, and it also reassembles each message.
module tb_ipg_tx_serializer;

    logic         clk;
    logic         rst_n;
    logic [519:0] s_msg_data;
    logic         s_msg_valid;
    logic         s_msg_ready;
    logic [6:0]   slot_len;
    logic [63:0]  tx_ipg_data;
    logic [6:0]   tx_len;
    logic         tx_ipg_valid;
    logic         msg_done;
    logic         busy;

    ipg_tx_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_msg_data   (s_msg_data),
        .s_msg_valid  (s_msg_valid),
        .s_msg_ready  (s_msg_ready),
        .slot_len     (slot_len),
        .tx_ipg_data  (tx_ipg_data),
        .tx_len       (tx_len),
        .tx_ipg_valid (tx_ipg_valid),
        .msg_done     (msg_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [6:0]  l;
        logic        dn;
    } exp_t;

    exp_t         exp_q[$];
    logic [519:0] msg_q[$];
    int           cnt_q[$];
    int           pat[$];

    int n_total = 0;
    int n_pass  = 0;

    logic [519:0] rx_acc   = '0;
    int           rx_bits  = 0;
    int           rx_chunks = 0;

    task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [519:0] make_msg(input int seed, input int step);
        logic [519:0] m;
        for (int i = 0; i < 65; i++) m[i*8 +: 8] = 8'((seed + i * step) & 255);
        return m;
    endfunction

    function automatic int cond_slot(input int s);
        int e;
        e = (s > 64) ? 64 : s;
        return e - (e % 8);
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (tx_ipg_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_chunk", 520'(tx_ipg_data), 520'(0));
            end else begin
                e = exp_q.pop_front();
                chk("chunk_data", 520'(tx_ipg_data), 520'(e.d));
                chk("chunk_len", 520'(tx_len), 520'(e.l));
                chk("chunk_done", 520'(msg_done), 520'(e.dn));
            end
            if (tx_len > 0 && tx_len <= 64) begin
                rx_acc  = (rx_acc << tx_len) | 520'(tx_ipg_data >> (7'd64 - tx_len));
                rx_bits = rx_bits + int'(tx_len);
            end
            rx_chunks++;
            if (msg_done === 1'b1) begin
                if (msg_q.size() == 0) begin
                    chk("unexpected_done", 520'(1), 520'(0));
                end else begin
                    chk("reassembled_msg", rx_acc, msg_q.pop_front());
                    chk("msg_bits", 520'(rx_bits), 520'(520));
                    chk("chunk_count", 520'(rx_chunks), 520'(cnt_q.pop_front()));
                end
                rx_acc = '0; rx_bits = 0; rx_chunks = 0;
            end
        end else begin
            chk("idle_outputs_zero", {tx_ipg_data, tx_len, msg_done}, '0);
        end
        if (rst_n === 1'b0) begin
            rx_acc = '0; rx_bits = 0; rx_chunks = 0;
        end
    end

    // Driver: offers the message, then plays pat[] cyclically as slot_len
    // and pushes the chunk each slot should produce.
    task automatic send_msg(input logic [519:0] m, input int exp_chunks, input int max_chunks);
        int   bl, k, e, n, cyc, got;
        logic [519:0] sr;
        exp_t x;
        cyc = 0;
        while (s_msg_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("ready_wait", 520'(cyc < 50), 520'(1));
        s_msg_valid = 1'b1;
        s_msg_data  = m;
        slot_len    = 7'd64;
        @(negedge clk);
        s_msg_valid = 1'b0;
        chk("busy_in_send", 520'(busy), 520'(1));
        chk("ready_in_send", 520'(s_msg_ready), 520'(0));
        if (max_chunks == 0) begin
            msg_q.push_back(m);
            cnt_q.push_back(exp_chunks);
        end
        bl = 520; sr = m; k = 0; got = 0;
        while (bl > 0 && k < 300 && (max_chunks == 0 || got < max_chunks)) begin
            slot_len = 7'(pat[k % pat.size()]);
            e = cond_slot(pat[k % pat.size()]);
            n = (e < bl) ? e : bl;
            if (n > 0) begin
                x.d = '0;
                for (int b = 0; b < n; b++) x.d[63-b] = sr[519-b];
                x.l  = 7'(n);
                x.dn = (bl == n);
                exp_q.push_back(x);
                sr = sr << n;
                bl = bl - n;
                got++;
            end
            k++;
            @(negedge clk);
        end
        slot_len = 7'd0;
        if (max_chunks == 0) chk("send_bound", 520'(bl), 520'(0));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || msg_q.size() != 0) && cyc < 30) begin @(negedge clk); cyc++; end
        chk("drain_wait", 520'(cyc < 30), 520'(1));
    endtask

    logic [519:0] m1, m2, m3, m4;

    initial begin
        m1 = make_msg(11, 37);
        m2 = make_msg(200, 5);
        m3 = make_msg(3, 91);
        m4 = make_msg(128, 13);
        rst_n       = 1'b0;
        s_msg_valid = 1'b0;
        s_msg_data  = '0;
        slot_len    = 7'd64;

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {tx_ipg_data, tx_len, tx_ipg_valid, msg_done, busy}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 520'(s_msg_ready), 520'(1));
        chk("rst_busy", 520'(busy), 520'(0));

        // Constant 56: ten chunks, with a 16-bit tail.
        pat = {56};
        send_msg(m1, 10, 0);
        // Constant 64: nine chunks, with an 8-bit tail.
        pat = {64};
        send_msg(m2, 9, 0);
        // Alternating 56/0 stalls every other cycle.
        pat = {56, 0};
        send_msg(m3, 10, 0);
        // Unaligned and oversize slots.
        pat = {60};
        send_msg(m4, 10, 0);
        pat = {72};
        send_msg(m1, 9, 0);
        pat = {5, 56, 5, 5};
        send_msg(m2, 10, 0);
        drain();
        chk("idle_busy", 520'(busy), 520'(0));

        // Reset in the middle of a message, after three chunks.
        pat = {56};
        send_msg(m3, 0, 3);
        rst_n    = 1'b0;
        slot_len = 7'd56;
        @(negedge clk);
        chk("midrst_outputs", {tx_ipg_data, tx_len, tx_ipg_valid, msg_done}, '0);
        chk("midrst_ready", 520'(s_msg_ready), 520'(1));
        chk("midrst_busy", 520'(busy), 520'(0));
        chk("midrst_exp_empty", 520'(exp_q.size()), 520'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send_msg(m4, 10, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", n_total);
        $fatal(1, "timeout");
    end

endmodule
